// File: rtl/irq_pulse_gen_pkg.sv
// Shared types and width helpers for the irq_pulse_gen interrupt generator.
// Also holds the fixed-width port bundles used by wrappers up to 32 sources.
package PkgIrqPulseGen;

   localparam int unsigned MAX_SRC  = 32;
   localparam int unsigned MAX_ID_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      HOLDOFF
   } state_t;

   function automatic int unsigned id_width(input int unsigned num_src);
      return (num_src <= 1) ? 1 : $clog2(num_src);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned pulse_len,
                                             input int unsigned holdoff_len);
      int unsigned longest;
      longest = (pulse_len > holdoff_len) ? pulse_len : holdoff_len;
      return $clog2(longest + 1);
   endfunction

   typedef struct packed {
      logic [MAX_SRC-1:0] src_in;
      logic [MAX_SRC-1:0] src_en;
      logic [MAX_SRC-1:0] clr_pending;
      logic               wait_for_mem;
   } PortIn_IrqPulseGen;

   typedef struct packed {
      logic                irq_out;
      logic [MAX_ID_W-1:0] irq_id;
      logic [MAX_SRC-1:0]  pending;
   } PortOut_IrqPulseGen;

endpackage

// File: rtl/irq_pulse_gen_prio_enc.sv
// Combinational fixed-priority encoder: the lowest-index active request wins.
module irq_prio_enc
   import PkgIrqPulseGen::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = id_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [ID_W-1:0]    index
);

   always_comb begin
      valid = |req;
      index = '0;
      // Scan from the top so the lowest set bit is the last one written.
      for (int unsigned i = NUM_SRC; i > 0; i--) begin
         if (req[i-1]) begin
            index = ID_W'(i - 1);
         end
      end
   end

endmodule

// File: rtl/irq_pulse_gen.sv
// Multi-source interrupt generator: latches, masks and prioritises requests,
// then emits a stall-aware timed pulse on irq_out with the winning source ID.
module irq_pulse_gen
   import PkgIrqPulseGen::*;
#(
   parameter  int unsigned        NUM_SRC     = 4,
   parameter  logic [NUM_SRC-1:0] EDGE_MASK   = '1,
   parameter  int unsigned        PULSE_LEN   = 3,
   parameter  int unsigned        HOLDOFF_LEN = 2,
   localparam int unsigned        ID_W        = id_width(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic [NUM_SRC-1:0] src_en,
   input  logic [NUM_SRC-1:0] clr_pending,
   input  logic               wait_for_mem,
   output logic               irq_out,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] pending
);

   localparam int unsigned     CNT_W      = cnt_width(PULSE_LEN, HOLDOFF_LEN);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [NUM_SRC-1:0] src_prev;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] set_vec;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] eligible;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    win_id;
   logic               win_valid;
   logic               dispatch;

   // Edge sources need a low->high transition; level sources set while high.
   assign set_vec  = src_in & (~EDGE_MASK | ~src_prev);
   assign eligible = pend_q & src_en;

   irq_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .req   (eligible),
      .valid (win_valid),
      .index (win_id)
   );

   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         clr_vec[i] = clr_pending[i] | (dispatch && (win_id == ID_W'(i)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         id_q     <= '0;
         pend_q   <= '0;
         src_prev <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         src_prev <= src_in;
         pend_q   <= (pend_q & ~clr_vec) | set_vec;
         if (dispatch) begin
            id_q <= win_id;
         end
      end
   end

   // The last holdoff cycle may dispatch, so the forced low gap between
   // pulses is exactly HOLDOFF_LEN cycles rather than HOLDOFF_LEN + 1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dispatch  = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid && !wait_for_mem) begin
               dispatch  = 1'b1;
               state_nxt = ASSERT;
               cnt_nxt   = PULSE_LOAD;
            end
         end
         ASSERT: begin
            if (!wait_for_mem) begin
               if (cnt == '0) begin
                  if (HOLDOFF_LEN == 0) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = HOLDOFF;
                     cnt_nxt   = HOLD_LOAD;
                  end
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
         end
         HOLDOFF: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_ONE;
            end else if (win_valid && !wait_for_mem) begin
               dispatch  = 1'b1;
               state_nxt = ASSERT;
               cnt_nxt   = PULSE_LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      irq_out = (state == ASSERT);
      irq_id  = id_q;
      pending = pend_q;
   end

endmodule

// File: tb/tb_irq_pulse_gen.sv
// Bench for irq_pulse_gen: a cycle-count reference model checked every cycle,
// plus directed scenarios with hand-computed pulse timings.
module tb_irq_pulse_gen;

   localparam int unsigned NS = 4;
   localparam int unsigned PL = 3;
   localparam int unsigned HL = 2;
   localparam logic [3:0]  EM = 4'b0111;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src_in, src_en, clr_pending;
   logic       wait_for_mem;
   logic       irq_out;
   logic [1:0] irq_id;
   logic [3:0] pending;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   irq_pulse_gen #(
      .NUM_SRC     (NS),
      .EDGE_MASK   (EM),
      .PULSE_LEN   (PL),
      .HOLDOFF_LEN (HL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .src_in       (src_in),
      .src_en       (src_en),
      .clr_pending  (clr_pending),
      .wait_for_mem (wait_for_mem),
      .irq_out      (irq_out),
      .irq_id       (irq_id),
      .pending      (pending)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: high/low cycles still owed, pending bits, last ID.
   logic [3:0] m_pend, m_prev, m_next, em_v;
   int         hi_left, lo_left, m_id, m_win;
   bit         m_fire, model_ok = 1'b0;

   always @(posedge clk) begin
      em_v = EM;
      if (rst) begin
         m_pend = '0; m_prev = '0; hi_left = 0; lo_left = 0; m_id = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         m_win = -1;
         for (int i = NS - 1; i >= 0; i--)
            if (m_pend[i] && src_en[i]) m_win = i;
         m_fire = (hi_left == 0) && (lo_left <= 1) && (m_win >= 0) && !wait_for_mem;
         if (hi_left > 0) begin
            if (!wait_for_mem) begin
               hi_left--;
               if (hi_left == 0) lo_left = HL;
            end
         end else if (lo_left > 0) begin
            lo_left--;
         end
         m_next = m_pend & ~clr_pending;
         if (m_fire) begin
            m_next[m_win] = 1'b0;
            m_id    = m_win;
            hi_left = PL;
            lo_left = 0;
         end
         for (int i = 0; i < NS; i++)
            if (src_in[i] && (!em_v[i] || !m_prev[i])) m_next[i] = 1'b1;
         m_pend = m_next;
         m_prev = src_in;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("irq_out", 32'(irq_out), 32'(hi_left > 0));
         chk("irq_id", 32'(irq_id), 32'(m_id));
         chk("pending", 32'(pending), 32'(m_pend));
      end
   end

   task automatic wait_rise(input int budget, input string name);
      int n = 0;
      while (!irq_out && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!irq_out) chk({name, "_timeout"}, 32'(irq_out), 32'd1);
   endtask

   task automatic count_high(output int n);
      n = 0;
      while (irq_out && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      src_in = '0; clr_pending = '0; wait_for_mem = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   int n_hi, t1, t2;

   initial begin
      rst = 1'b1; src_in = '0; src_en = '0; clr_pending = '0; wait_for_mem = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_irq_out", 32'(irq_out), 32'd0);
      chk("rst_irq_id", 32'(irq_id), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      rst = 1'b0;
      src_en = 4'b1111;
      idle(3);

      // Single edge on source 2
      src_in = 4'b0100;
      @(negedge clk);
      chk("t1_pending_set", 32'(pending), 32'd4);
      chk("t1_no_irq_yet", 32'(irq_out), 32'd0);
      src_in = '0;
      @(negedge clk);
      chk("t1_rise", 32'(irq_out), 32'd1);
      chk("t1_id", 32'(irq_id), 32'd2);
      chk("t1_pending_clr", 32'(pending), 32'd0);
      count_high(n_hi);
      chk("t1_high_len", 32'(n_hi), 32'd3);
      @(negedge clk);
      chk("t1_holdoff_low", 32'(irq_out), 32'd0);
      idle(8);

      // Two sources at once: priority and back-to-back spacing
      src_in = 4'b1010;
      @(negedge clk);
      src_in = '0;
      wait_rise(10, "t2_first");
      t1 = cyc;
      chk("t2_first_id", 32'(irq_id), 32'd1);
      count_high(n_hi);
      wait_rise(10, "t2_second");
      t2 = cyc;
      chk("t2_spacing", 32'(t2 - t1), 32'd5);
      chk("t2_second_id", 32'(irq_id), 32'd3);
      idle(10);

      // Memory stall gating and pulse stretching
      wait_for_mem = 1'b1;
      src_in = 4'b0001;
      @(negedge clk);
      src_in = '0;
      repeat (3) @(negedge clk);
      chk("t3_stalled_low", 32'(irq_out), 32'd0);
      chk("t3_stalled_pend", 32'(pending), 32'd1);
      wait_for_mem = 1'b0;
      @(negedge clk);
      chk("t3_release_rise", 32'(irq_out), 32'd1);
      @(negedge clk);
      wait_for_mem = 1'b1;
      repeat (4) @(negedge clk);
      wait_for_mem = 1'b0;
      count_high(n_hi);
      chk("t3_stretched_len", 32'(5 + n_hi), 32'd7);
      idle(10);

      // Level source 3 held high: periodic re-trigger, then masked
      src_in = 4'b1000;
      wait_rise(10, "t4_first");
      t1 = cyc;
      chk("t4_id", 32'(irq_id), 32'd3);
      for (int k = 0; k < 3; k++) begin
         count_high(n_hi);
         wait_rise(10, "t4_repeat");
         chk("t4_period", 32'(cyc - t1), 32'd5);
         chk("t4_repeat_id", 32'(irq_id), 32'd3);
         t1 = cyc;
      end
      src_en = 4'b0111;
      count_high(n_hi);
      chk("t4_masked_full_pulse", 32'(n_hi), 32'd3);
      n_hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (irq_out) n_hi++;
      end
      chk("t4_no_new_pulse", 32'(n_hi), 32'd0);
      chk("t4_pending_kept", 32'(pending[3]), 32'd1);
      src_in = '0;
      clr_pending = 4'b1000;
      @(negedge clk);
      clr_pending = '0;
      src_en = 4'b1111;
      idle(5);

      // Clear versus set priority
      src_en = 4'b1110;
      src_in = 4'b0001;
      clr_pending = 4'b0001;
      @(negedge clk);
      chk("t5_set_wins", 32'(pending[0]), 32'd1);
      src_in = '0; clr_pending = '0;
      repeat (2) @(negedge clk);
      clr_pending = 4'b0001;
      @(negedge clk);
      clr_pending = '0;
      chk("t5_clr_alone", 32'(pending[0]), 32'd0);
      src_en = 4'b1111;
      n_hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (irq_out) n_hi++;
      end
      chk("t5_no_pulse", 32'(n_hi), 32'd0);

      // Reset mid-pulse with an edge source held high
      src_in = 4'b0100;
      wait_rise(10, "t6_first");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_irq_out", 32'(irq_out), 32'd0);
      chk("t6_rst_pending", 32'(pending), 32'd0);
      chk("t6_rst_id", 32'(irq_id), 32'd0);
      wait_rise(6, "t6_refire");
      chk("t6_refire_id", 32'(irq_id), 32'd2);
      idle(10);

      // Randomised traffic checked by the model every cycle
      for (int k = 0; k < 3000; k++) begin
         src_in      = 4'($urandom) & 4'($urandom) & 4'($urandom);
         clr_pending = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
         wait_for_mem = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 19) == 0) src_en = 4'($urandom);
         rst = ($urandom_range(0, 399) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
